// File: rtl/vga_rect_arbiter_pkg.sv
// Shared widths, frame limits, FSM encoding and rectangle command type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_rect_arbiter_pkg;

    localparam int X_W       = 8;
    localparam int Y_W       = 7;
    localparam int C_W       = 3;
    localparam int X_MAX_DEF = 159;
    localparam int Y_MAX_DEF = 119;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] x0;
        logic [Y_W-1:0] y0;
        logic [X_W-1:0] w;
        logic [Y_W-1:0] h;
        logic [C_W-1:0] c;
    } rect_t;

    function automatic logic rect_empty(input rect_t r);
        return (r.w == '0) || (r.h == '0);
    endfunction

endpackage

// File: rtl/vga_rect_arbiter_if.sv
// Requester command bus plus the pixel write port towards vga_adapter.
// Latency: n/a (wiring only).
// Backpressure: req is level-held by the requester until gnt.
interface vga_rect_arbiter_if #(
    parameter int NUM_REQ = 3
);
    import vga_rect_arbiter_pkg::*;

    logic [NUM_REQ-1:0]     req;
    logic [X_W*NUM_REQ-1:0] cmd_x;
    logic [Y_W*NUM_REQ-1:0] cmd_y;
    logic [X_W*NUM_REQ-1:0] cmd_w;
    logic [Y_W*NUM_REQ-1:0] cmd_h;
    logic [C_W*NUM_REQ-1:0] cmd_color;
    logic [NUM_REQ-1:0]     gnt;
    logic [NUM_REQ-1:0]     done;
    logic                   busy;
    logic [X_W-1:0]         x;
    logic [Y_W-1:0]         y;
    logic [C_W-1:0]         color;
    logic                   plot;

    modport master (
        output req, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  gnt, done, busy, x, y, color, plot
    );

    modport slave (
        input  req, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output gnt, done, busy, x, y, color, plot
    );

endinterface

// File: rtl/vga_rect_arbiter_rr_arbiter.sv
// Round-robin picker: first requester after 'last', wrapping modulo NUM_REQ.
// Latency: combinational.
// Backpressure: none; caller decides when the grant is consumed.
module vga_rect_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    logic [IDX_W-1:0] cand;

    // Walk from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (req[cand]) begin
                gnt_oh  = NUM_REQ'(1) << cand;
                gnt_idx = cand;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_rect_arbiter.sv
// Arbitrates rectangle fill commands and rasterises the winner, one pixel per clock.
// Latency: gnt 1 cycle after req sampled; command of w*h pixels costs w*h+2 cycles.
// Backpressure: req held until gnt; no new grant until the current rectangle is done.
module vga_rect_arbiter
    import vga_rect_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int X_MAX   = X_MAX_DEF,
    parameter int Y_MAX   = Y_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    vga_rect_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state, next_state;
    rect_t              cmd, cmd_sel;
    logic [IDX_W-1:0]   last, winner;
    logic [X_W-1:0]     cx;
    logic [Y_W-1:0]     cy;
    logic [NUM_REQ-1:0] arb_oh, gnt_q;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_vld;
    logic [8:0]         px, py;
    logic               row_end, rect_end;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [C_W-1:0]     color_q;
    logic               plot_q;

    vga_rect_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (bus.req),
        .last    (last),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_comb begin
        cmd_sel.x0 = bus.cmd_x[arb_idx*X_W +: X_W];
        cmd_sel.y0 = bus.cmd_y[arb_idx*Y_W +: Y_W];
        cmd_sel.w  = bus.cmd_w[arb_idx*X_W +: X_W];
        cmd_sel.h  = bus.cmd_h[arb_idx*Y_W +: Y_W];
        cmd_sel.c  = bus.cmd_color[arb_idx*C_W +: C_W];
    end

    // Sums kept one bit wider than the frame so off-screen pixels clip instead of wrapping.
    assign px       = {1'b0, cmd.x0} + {1'b0, cx};
    assign py       = {2'b00, cmd.y0} + {2'b00, cy};
    assign row_end  = (cx == cmd.w - 8'd1);
    assign rect_end = row_end && (cy == cmd.h - 7'd1);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (arb_vld) next_state = rect_empty(cmd_sel) ? ST_DONE : ST_DRAW;
            ST_DRAW: if (rect_end) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd     <= '0;
            last    <= IDX_W'(NUM_REQ - 1);
            winner  <= '0;
            cx      <= '0;
            cy      <= '0;
            gnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            plot_q  <= 1'b0;
        end else begin
            gnt_q  <= '0;
            plot_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        cmd    <= cmd_sel;
                        winner <= arb_idx;
                        last   <= arb_idx;
                        gnt_q  <= arb_oh;
                        cx     <= '0;
                        cy     <= '0;
                    end
                end
                ST_DRAW: begin
                    x_q     <= px[X_W-1:0];
                    y_q     <= py[Y_W-1:0];
                    color_q <= cmd.c;
                    plot_q  <= (px <= 9'(X_MAX)) && (py <= 9'(Y_MAX));
                    if (row_end) begin
                        cx <= '0;
                        cy <= cy + 7'd1;
                    end else begin
                        cx <= cx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = (state == ST_DONE) ? (NUM_REQ'(1) << winner) : '0;
    assign bus.busy  = (state != ST_IDLE);
    assign bus.x     = x_q;
    assign bus.y     = y_q;
    assign bus.color = color_q;
    assign bus.plot  = plot_q;

endmodule
